div_share_sched: RTL and testbench
==================================

// Module: div_share_sched
// PURPOSE
//  Shares one iterative restoring unsigned divider between NREQ requesters.
//  Each requester uses a valid/ready request port; one response port returns
//  the quotient, the remainder and the requester ID.
//  Arbitration is round-robin. The divider produces one quotient bit per cycle.
//  Sits between the user-input front end and the uo_out packing logic.
// PARAMETERS
//  W     4  operand width (dividend, divisor, quotient, remainder), W>=2
//  NREQ  2  number of requesters, 2..8
//  IDW   $clog2(NREQ)  requester ID width (derived localparam, not overridable)
// PORTS
//  clk            in   1         clock, rising edge
//  rst_n          in   1         asynchronous reset, active-low
//  ena            in   1         global enable; low = freeze
//  req_valid      in   NREQ      per-requester request valid
//  req_ready      out  NREQ      per-requester accept, one-hot or zero
//  req_dividend   in   NREQ*W    requester i occupies bits [i*W +: W]
//  req_divisor    in   NREQ*W    requester i occupies bits [i*W +: W]
//  rsp_valid      out  1         response valid
//  rsp_ready      in   1         response consumer ready
//  rsp_id         out  IDW       index of the requester that owns the response
//  rsp_quotient   out  W         quotient
//  rsp_remainder  out  W         remainder
//  rsp_dbz        out  1         divide-by-zero flag
//  busy           out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE and rr_ptr=0; internal regs cleared.
//   All outputs 0 at reset: req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy.
//  FSM states: IDLE -> RUN -> DONE -> IDLE. ZERO path: IDLE -> DONE directly.
//  IDLE, arbitration (combinational):
//   - grant = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NREQ.
//   - req_ready[grant]=1 only while state=IDLE and ena=1; all other bits 0.
//   - Accept = req_valid[i] & req_ready[i].
//  On accept:
//   - latch dividend, divisor and id; rr_ptr <= (grant+1) mod NREQ.
//   - divisor!=0: clear the partial remainder, set cnt=W-1, go to RUN.
//   - divisor==0: go to DONE next cycle with quotient={W{1}}, remainder={W{1}}, dbz=1.
//  RUN, one iteration per ena cycle, MSB first:
//   - trial = {rem[W-2:0], dvd[cnt]} - divisor, evaluated at W+1 bits.
//   - trial non-negative: rem <= trial and q[cnt] <= 1; otherwise rem <= shifted value and q[cnt] <= 0.
//   - After the cnt=0 iteration go to DONE.
//  DONE:
//   - rsp_valid=1; rsp_* come from registers and are stable while rsp_valid=1.
//   - rsp_valid & rsp_ready -> IDLE. A new grant can occur in the cycle after the handshake.
//   - rsp_dbz=0 for every non-zero divisor.
//  Latency, with ena held high and accept in cycle t:
//   - normal: rsp_valid is first high in cycle t+W+1.
//   - divide-by-zero: rsp_valid is first high in cycle t+1.
//   - Minimum throughput: one request per W+2 cycles.
//  Freeze: ena=0 holds state, cnt, rr_ptr and all registers; req_ready=0.
//   - rsp_valid keeps its value while frozen; a rsp_ready handshake is ignored while ena=0.
//  Request inputs may change freely when req_ready=0.
//   - Operands are sampled only at accept, so later changes never affect the running division.
//  Simultaneous requests: exactly one grant per accept; no requester starves.
//   - With all NREQ continuously valid, each is served once per NREQ grants.
//  Dividend < divisor: quotient=0, remainder=dividend. Dividend=0: quotient=0, remainder=0.
//  Reset mid-operation: immediate abort to the reset state; no response for the aborted request.
// TESTING (W=4, NREQ=2)
//  1. Single request: req0 13/3 -> rsp_id=0, q=4, r=1, dbz=0, rsp_valid first high at t+5.
//  2. Divide by zero: req1 9/0 -> rsp_id=1, q=F, r=F, dbz=1 at t+1.
//  3. Fairness: req0 and req1 both held valid for 4 grants -> grant order 0,1,0,1.
//     - rr_ptr=0 after reset, so requester 0 is granted first.
//  4. Backpressure: rsp_ready=0 for 10 cycles on 15/4 -> q=3, r=3 held stable.
//     - No req_ready asserted until the handshake completes.
//  5. ena low for 3 cycles mid-RUN on 14/5 -> result q=2, r=4.
//     - Latency extended by exactly 3 cycles.
//  6. rst_n pulsed during RUN -> all outputs 0 in the same cycle.
//     - No rsp_valid for the aborted request.
//     - The next request from requester 0 is granted first.
//  Sweep: all 256 dividend/divisor pairs via req0 -> compare against the / and % reference.

Source files
------------

// File: rtl/div_share_sched.sv
// div_share_sched: one iterative restoring unsigned divider shared by NREQ
// requesters under round-robin arbitration. One quotient bit per enabled cycle.
module div_share_sched #(
  parameter  int W    = 4,
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_dividend,
  input  logic [NREQ*W-1:0]   req_divisor,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [W-1:0]        rsp_quotient,
  output logic [W-1:0]        rsp_remainder,
  output logic                rsp_dbz,
  output logic                busy
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           dbz_q, dbz_d;

  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic           accept;
  logic [W-1:0]   sel_dvd, sel_dvs;
  logic [W-1:0]   shifted;
  logic [W:0]     trial;

  // Round-robin search starting at rr_ptr, wrapping at NREQ.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  // Grant is offered only in IDLE with ena high; rst_n gating keeps ready low
  // during reset even though the state already reads IDLE.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && ena && rst_n && gnt_found) req_ready[gnt_id] = 1'b1;
  end

  assign accept  = |(req_valid & req_ready);
  assign sel_dvd = req_dividend[gnt_id*W +: W];
  assign sel_dvs = req_divisor[gnt_id*W +: W];

  // The partial remainder's MSB is provably zero before each shift, so W bits
  // of shifted value plus a borrow bit are enough for the trial subtraction.
  assign shifted = {rem_q[W-2:0], dvd_q[cnt_q]};
  assign trial   = {1'b0, shifted} - {1'b0, dvs_q};

  // Next-state and datapath update; everything holds while ena is low.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    dbz_d    = dbz_q;
    if (ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            id_d     = gnt_id;
            dvd_d    = sel_dvd;
            dvs_d    = sel_dvs;
            rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
            if (sel_dvs == '0) begin
              quo_d   = '1;
              rem_d   = '1;
              dbz_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              quo_d   = '0;
              rem_d   = '0;
              dbz_d   = 1'b0;
              cnt_d   = CW'(W-1);
              state_d = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!trial[W]) begin
            rem_d        = trial[W-1:0];
            quo_d[cnt_q] = 1'b1;
          end else begin
            rem_d        = shifted;
            quo_d[cnt_q] = 1'b0;
          end
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_DONE: begin
          if (rsp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      dbz_q    <= dbz_d;
    end
  end

  assign rsp_valid     = (state_q == S_DONE);
  assign busy          = (state_q != S_IDLE);
  assign rsp_id        = id_q;
  assign rsp_quotient  = quo_q;
  assign rsp_remainder = rem_q;
  assign rsp_dbz       = dbz_q;

endmodule

// File: tb/tb_div_share_sched.sv
// Bench for div_share_sched (W=4, NREQ=2): directed scenarios, full operand
// sweep and random traffic against a plain-arithmetic reference model.
module tb_div_share_sched;
  localparam int W = 4;
  localparam int NREQ = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_dividend;
  logic [7:0] req_divisor;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [0:0] rsp_id;
  logic [3:0] rsp_quotient;
  logic [3:0] rsp_remainder;
  logic       rsp_dbz;
  logic       busy;

  int nvec = 0;
  int nerr = 0;
  int rr   = 0;   // model round-robin pointer

  div_share_sched #(.W(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One full transaction: offer, accept, wait for response, optional stall
  // (first stall cycle tries a handshake with ena low), then handshake.
  // fz_len freezes ena for that many cycles starting one cycle after accept.
  task automatic xact(input logic [1:0] vm, input logic [7:0] dd, input logic [7:0] ds,
                      input int stall, input int fz_len);
    int g, n, explat;
    logic [3:0] a, b, eq, er;
    logic edbz;
    g = vm[rr] ? rr : (rr + 1) % NREQ;
    a = dd[g*4 +: 4];
    b = ds[g*4 +: 4];
    edbz   = (b == 0);
    eq     = edbz ? 4'hF : a / b;
    er     = edbz ? 4'hF : a % b;
    explat = edbz ? 1 : W + 1 + fz_len;
    req_valid = vm; req_dividend = dd; req_divisor = ds;
    @(negedge clk);
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin @(negedge clk); n++; end
    chk("grant", 32'(req_ready), 32'(1) << g);
    rr = (g + 1) % NREQ;
    @(posedge clk); #1;
    // operands change freely after accept; they must not affect the result
    req_valid = 2'b11; req_dividend = 8'($urandom); req_divisor = 8'($urandom);
    n = 0;
    while (1) begin
      ena = !(fz_len > 0 && n >= 1 && n < 1 + fz_len);
      @(negedge clk); n++;
      if (rsp_valid || n >= 40) break;
      @(posedge clk); #1;
    end
    ena = 1'b1;
    chk("latency", n, explat);
    chk("rsp_id", 32'(rsp_id), g);
    chk("quot", 32'(rsp_quotient), 32'(eq));
    chk("rem", 32'(rsp_remainder), 32'(er));
    chk("dbz", 32'(rsp_dbz), 32'(edbz));
    chk("ready_done", 32'(req_ready), 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      ena = (i != 0); rsp_ready = (i == 0);
      @(negedge clk);
      chk("hold", {rsp_valid, rsp_quotient, rsp_remainder, rsp_dbz, req_ready},
          {1'b1, eq, er, edbz, 2'b00});
    end
    @(posedge clk); #1;
    ena = 1'b1; rsp_ready = 1'b1; req_valid = 2'b00;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("after_hs", {rsp_valid, busy}, 0);
  endtask

  initial begin
    logic [1:0] vm;
    logic       seen;
    rst_n = 1'b0; ena = 1'b1; rsp_ready = 1'b0;
    req_valid = 2'b11; req_dividend = 8'hD9; req_divisor = 8'h33;
    repeat (2) @(negedge clk);
    chk("reset_outs", {req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy}, 0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // fairness from reset: 0,1,0,1 (also covered by the model pointer)
    for (int i = 0; i < 4; i++) begin
      chk("rr_expect", rr, i % 2);
      xact(2'b11, 8'($urandom), 8'($urandom | 8'h11), 0, 0);
    end
    xact(2'b01, 8'h0D, 8'h03, 0, 0);          // 13/3
    xact(2'b10, 8'h90, 8'h00, 0, 0);          // 9/0 on requester 1
    xact(2'b01, 8'h0F, 8'h04, 10, 0);         // backpressure 15/4
    xact(2'b01, 8'h0E, 8'h05, 0, 3);          // freeze mid-run 14/5
    xact(2'b01, 8'h03, 8'h09, 0, 0);          // dividend < divisor
    xact(2'b01, 8'h00, 8'h07, 0, 0);          // dividend 0

    // reset during RUN
    req_valid = 2'b01; req_dividend = 8'h0E; req_divisor = 8'h05;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy}, 0);
    rr = 0;
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); seen |= rsp_valid | busy; end
    chk("no_rsp_aborted", 32'(seen), 0);
    @(posedge clk); #1;
    xact(2'b11, 8'h52, 8'h31, 0, 0);          // requester 0 first after reset

    // full sweep on requester 0
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        xact(2'b01, {4'($urandom), 4'(a)}, {4'($urandom), 4'(b)}, 0, 0);

    // random traffic
    repeat (60) begin
      vm = 2'($urandom_range(1, 3));
      xact(vm, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)) * 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
